// File: rtl/tof_frame_reader.sv
// Interrupt-driven ranging-frame reader: on a ToF interrupt it burst-reads NUM_ZONES big-endian
// 16-bit distances over a byte-level I2C master and publishes the whole frame atomically.
module tof_frame_reader #(
    parameter int unsigned NUM_ZONES       = 64,
    parameter logic [15:0] DATA_START_ADDR = 16'h0400,
    parameter int unsigned MAX_RETRY       = 3,
    parameter logic [23:0] INT_TIMEOUT     = 24'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic                   cmd_cont,
    input  logic                   cmd_stop,
    input  logic                   ToF_INT,
    input  logic                   ready,
    input  logic                   error_in,
    input  logic [7:0]             i2c_data_in,
    output logic                   start,
    output logic                   is_read,
    output logic                   nb_of_bytes,
    output logic [15:0]            register_address,
    output logic                   busy,
    output logic                   frame_valid,
    output logic [15:0]            frame_count,
    output logic                   err_sticky,
    output logic                   timeout_sticky,
    output logic [NUM_ZONES*16-1:0] distance_mm
);

    localparam int unsigned NUM_BYTES = 2 * NUM_ZONES;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INT,
        S_REQ,
        S_WAIT_DONE,
        S_COMMIT
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [RETRY_W-1:0]      r_retry;
    logic [23:0]             r_timer;
    logic                    r_cont;
    logic                    r_stop_pending;
    logic                    r_start;
    logic                    r_is_read;
    logic                    r_nb;
    logic [15:0]             r_addr;
    logic                    r_frame_valid;
    logic [15:0]             r_frame_count;
    logic                    r_err_sticky;
    logic                    r_timeout_sticky;
    logic [NUM_ZONES*16-1:0] r_shadow;
    logic [NUM_ZONES*16-1:0] r_distance;

    logic r_int_s1, r_int_s2, r_int_s3;
    logic w_int_fall;
    logic w_stop_now;

    // Sync FFs idle high so reset release never fabricates a falling edge on an idle pin.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int_s1 <= 1'b1;
            r_int_s2 <= 1'b1;
            r_int_s3 <= 1'b1;
        end else begin
            r_int_s1 <= ToF_INT;
            r_int_s2 <= r_int_s1;
            r_int_s3 <= r_int_s2;
        end
    end

    assign w_int_fall = r_int_s3 & ~r_int_s2;
    assign w_stop_now = r_stop_pending | cmd_stop;

    // NOTE: the shadow buffer is an ordinary register bank, so it takes the async reset like the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_retry          <= '0;
            r_timer          <= '0;
            r_cont           <= 1'b0;
            r_stop_pending   <= 1'b0;
            r_start          <= 1'b0;
            r_is_read        <= 1'b0;
            r_nb             <= 1'b0;
            r_addr           <= '0;
            r_frame_valid    <= 1'b0;
            r_frame_count    <= '0;
            r_err_sticky     <= 1'b0;
            r_timeout_sticky <= 1'b0;
            r_shadow         <= '0;
            r_distance       <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_stop_pending <= 1'b0;
                    if (cmd_start) begin
                        r_err_sticky     <= 1'b0;
                        r_timeout_sticky <= 1'b0;
                        r_cont           <= cmd_cont;
                        r_timer          <= '0;
                        r_state          <= S_WAIT_INT;
                    end
                end
                S_WAIT_INT: begin
                    r_timer <= r_timer + 24'd1;
                    if (cmd_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_int_fall) begin
                        r_idx   <= '0;
                        r_retry <= '0;
                        r_state <= S_REQ;
                    end else if ((INT_TIMEOUT != 24'd0) && (r_timer + 24'd1 == INT_TIMEOUT)) begin
                        r_timeout_sticky <= 1'b1;
                        r_state          <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (cmd_stop) r_stop_pending <= 1'b1;
                    // Waiting for ready low keeps a stale done from completing the new request.
                    if (!ready) begin
                        r_start   <= 1'b1;
                        r_is_read <= 1'b1;
                        r_addr    <= DATA_START_ADDR + 16'(r_idx);
                        r_nb      <= (r_idx != LAST_IDX);
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (cmd_stop) r_stop_pending <= 1'b1;
                    if (ready) begin
                        r_start   <= 1'b0;
                        r_is_read <= 1'b0;
                        if (!error_in) begin
                            // Even byte index is the zone MSB, so the byte lane is idx with bit 0 flipped.
                            r_shadow[{r_idx ^ IDX_W'(1), 3'b000} +: 8] <= i2c_data_in;
                            r_retry <= '0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= S_COMMIT;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= S_REQ;
                            end
                        end else if (r_retry < RETRY_LIM) begin
                            r_retry <= r_retry + RETRY_W'(1);
                            r_state <= S_REQ;
                        end else begin
                            r_err_sticky   <= 1'b1;
                            r_shadow       <= '0;
                            r_stop_pending <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    end
                end
                S_COMMIT: begin
                    r_distance    <= r_shadow;
                    r_frame_valid <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                    if (r_cont && !w_stop_now) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_INT;
                    end else begin
                        r_stop_pending <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start            = r_start;
    assign is_read          = r_is_read;
    assign nb_of_bytes      = r_nb;
    assign register_address = r_addr;
    assign busy             = (r_state != S_IDLE);
    assign frame_valid      = r_frame_valid;
    assign frame_count      = r_frame_count;
    assign err_sticky       = r_err_sticky;
    assign timeout_sticky   = r_timeout_sticky;
    assign distance_mm      = r_distance;

endmodule
